// File: rtl/vga_pkg.sv
// Shared raster timing constants and helpers for the video pipeline.
// 800x600@60 with a 40 MHz pixel clock.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int HOR_PIXELS       = 800;
  localparam int VGA_H_SYNC_START = 840;
  localparam int VGA_H_SYNC_LEN   = 128;
  localparam int VGA_H_TOTAL      = 1056;

  localparam int VER_PIXELS       = 600;
  localparam int VGA_V_SYNC_START = 601;
  localparam int VGA_V_SYNC_LEN   = 4;
  localparam int VGA_V_TOTAL      = 628;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   cnt_ext_t;

  // End bound is one bit wider so a window may close exactly at 2048.
  function automatic logic in_win(
    input cnt_t     c,
    input cnt_t     s,
    input cnt_ext_t e
  );
    return ({1'b0, c} >= {1'b0, s}) && ({1'b0, c} < e);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Raster bundle from the timing generator to the draw stages.
// One producer (out) and any number of consumers (in).
interface vga_if;
  import vga_pkg::*;

  cnt_t        hcount;
  cnt_t        vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (
    output hcount, vcount,
    output hsync, vsync,
    output hblnk, vblnk,
    output rgb
  );

  modport in (
    input hcount, vcount,
    input hsync, vsync,
    input hblnk, vblnk,
    input rgb
  );

endinterface

// File: rtl/vga_timing_gen_sync_counter.sv
// Wrap counter 0..TOTAL-1 with next-state and carry outputs.
// carry_o marks the enabled cycle on which the count wraps.
module sync_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = VGA_H_TOTAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output cnt_t cnt_o,
  output cnt_t cnt_d_o,
  output logic carry_o
);

  localparam cnt_t LAST = CNT_W'(TOTAL - 1);

  cnt_t cnt_q;
  cnt_t cnt_d;
  logic wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign carry_o = en_i & wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator, head of the video pipeline.
// All fields are registered from next-state counts so they never skew.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE     = HOR_PIXELS,
  parameter int   H_SYNC_START = VGA_H_SYNC_START,
  parameter int   H_SYNC_LEN   = VGA_H_SYNC_LEN,
  parameter int   H_TOTAL      = VGA_H_TOTAL,
  parameter int   V_ACTIVE     = VER_PIXELS,
  parameter int   V_SYNC_START = VGA_V_SYNC_START,
  parameter int   V_SYNC_LEN   = VGA_V_SYNC_LEN,
  parameter int   V_TOTAL      = VGA_V_TOTAL,
  parameter logic SYNC_POL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  vga_if.out   out,
  output logic line_start,
  output logic frame_start
);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_chk_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2048");
  end

  if (H_ACTIVE >= H_SYNC_START ||
      H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_chk_h
    $error("vga_timing_gen: bad horizontal timing");
  end

  if (V_ACTIVE >= V_SYNC_START ||
      V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_chk_v
    $error("vga_timing_gen: bad vertical timing");
  end

  localparam cnt_t     HA  = CNT_W'(H_ACTIVE);
  localparam cnt_t     HSS = CNT_W'(H_SYNC_START);
  localparam cnt_ext_t HSE = (CNT_W+1)'(H_SYNC_START + H_SYNC_LEN);
  localparam cnt_t     VA  = CNT_W'(V_ACTIVE);
  localparam cnt_t     VSS = CNT_W'(V_SYNC_START);
  localparam cnt_ext_t VSE = (CNT_W+1)'(V_SYNC_START + V_SYNC_LEN);

  // run_q holds the counters at (0,0) for the first edge after reset.
  logic run_q;
  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic h_carry, v_carry;

  logic hblnk_q, hblnk_d;
  logic vblnk_q, vblnk_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  sync_counter #(
    .TOTAL (H_TOTAL)
  ) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (run_q),
    .cnt_o   (h_q),
    .cnt_d_o (h_d),
    .carry_o (h_carry)
  );

  sync_counter #(
    .TOTAL (V_TOTAL)
  ) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (h_carry),
    .cnt_o   (v_q),
    .cnt_d_o (v_d),
    .carry_o (v_carry)
  );

  always_comb begin
    hblnk_d = (h_d >= HA);
    vblnk_d = (v_d >= VA);
    hsync_d = in_win(h_d, HSS, HSE) ? SYNC_POL : ~SYNC_POL;
    vsync_d = in_win(v_d, VSS, VSE) ? SYNC_POL : ~SYNC_POL;
    ls_d    = (h_d == '0);
    // (0,0) is reached either at frame wrap or on the post-reset hold.
    fs_d    = ls_d & (v_carry | ~run_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign out.hcount  = h_q;
  assign out.vcount  = v_q;
  assign out.hblnk   = hblnk_q;
  assign out.vblnk   = vblnk_q;
  assign out.hsync   = hsync_q;
  assign out.vsync   = vsync_q;
  assign out.rgb     = 12'h000;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size horizontal timing on dut0, whole small
// frames, inverted polarity and mid-frame reset on dut1.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        ls;
    logic        fs;
  } smp_t;

  localparam int NREC = 300;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  logic ls0, fs0, ls1, fs1;

  int vectors = 0;
  int miscompares = 0;

  smp_t rec1 [NREC];
  smp_t rec2 [NREC];

  vga_if vif0 ();
  vga_if vif1 ();

  vga_timing_gen dut0 (
    .clk         (clk),
    .rst_n       (rst0_n),
    .out         (vif0),
    .line_start  (ls0),
    .frame_start (fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE     (8),
    .H_SYNC_START (10),
    .H_SYNC_LEN   (3),
    .H_TOTAL      (16),
    .V_ACTIVE     (4),
    .V_SYNC_START (5),
    .V_SYNC_LEN   (2),
    .V_TOTAL      (8),
    .SYNC_POL     (1'b0)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst1_n),
    .out         (vif1),
    .line_start  (ls1),
    .frame_start (fs1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic smp_t smp1();
    smp_t s;
    s.h  = vif1.hcount;
    s.v  = vif1.vcount;
    s.hs = vif1.hsync;
    s.vs = vif1.vsync;
    s.hb = vif1.hblnk;
    s.vb = vif1.vblnk;
    s.ls = ls1;
    s.fs = fs1;
    return s;
  endfunction

  initial begin
    int n, cnt, first, hb_h, hs_cnt, hs_first, hs_last, prev_h;
    bit hb_seen, found;

    // Reset held for 5 clocks on both instances
    repeat (5) step();
    chk("rst0_h", int'(vif0.hcount), 0);
    chk("rst0_v", int'(vif0.vcount), 0);
    chk("rst0_hs", int'(vif0.hsync), 0);
    chk("rst0_vs", int'(vif0.vsync), 0);
    chk("rst0_hb", int'(vif0.hblnk), 0);
    chk("rst0_vb", int'(vif0.vblnk), 0);
    chk("rst0_rgb", int'(vif0.rgb), 0);
    chk("rst0_ls", int'(ls0), 0);
    chk("rst0_fs", int'(fs0), 0);
    chk("rst1_hs", int'(vif1.hsync), 1);
    chk("rst1_vs", int'(vif1.vsync), 1);

    // Release dut0
    rst0_n = 1'b1;
    step();
    chk("rel_h", int'(vif0.hcount), 0);
    chk("rel_v", int'(vif0.vcount), 0);
    chk("rel_ls", int'(ls0), 1);
    chk("rel_fs", int'(fs0), 1);
    chk("rel_hs", int'(vif0.hsync), 0);
    chk("rel_vs", int'(vif0.vsync), 0);
    chk("rel_rgb", int'(vif0.rgb), 0);
    step();
    chk("run_h", int'(vif0.hcount), 1);
    chk("run_ls", int'(ls0), 0);
    chk("run_fs", int'(fs0), 0);

    // Horizontal sweep until hcount wraps
    hb_seen = 0; hb_h = -1;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    prev_h = int'(vif0.hcount);
    n = 0;
    while (vif0.hcount != 11'd0 && n < 3000) begin
      prev_h = int'(vif0.hcount);
      step();
      n++;
      if (vif0.hblnk && !hb_seen) begin
        hb_seen = 1;
        hb_h = int'(vif0.hcount);
      end
      if (vif0.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vif0.hcount);
        hs_last = int'(vif0.hcount);
      end
    end
    chk("h_wrap_bound", int'(n < 3000), 1);
    chk("hblnk_rise", hb_h, 800);
    chk("hsync_first", hs_first, 840);
    chk("hsync_last", hs_last, 967);
    chk("hsync_len", hs_cnt, 128);
    chk("h_before_wrap", prev_h, 1055);
    chk("v_after_wrap", int'(vif0.vcount), 1);
    chk("wrap_ls", int'(ls0), 1);
    chk("wrap_fs", int'(fs0), 0);
    chk("wrap_hb", int'(vif0.hblnk), 0);
    chk("wrap_vb", int'(vif0.vblnk), 0);

    n = 0;
    do begin
      step();
      n++;
    end while (!ls0 && n < 2000);
    chk("line_period", n, 1056);

    // Small-geometry instance with SYNC_POL=0
    rst1_n = 1'b1;
    for (int k = 0; k < NREC; k++) begin
      step();
      rec1[k] = smp1();
    end
    chk("s_rel_h", int'(rec1[0].h), 0);
    chk("s_rel_fs", int'(rec1[0].fs), 1);
    chk("s_rel_ls", int'(rec1[0].ls), 1);
    chk("s_rel_hs", int'(rec1[0].hs), 1);
    chk("s_run_h", int'(rec1[1].h), 1);
    chk("s_run_fs", int'(rec1[1].fs), 0);

    cnt = 0; first = -1;
    for (int k = 0; k < 16; k++) begin
      if (!rec1[k].hs) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk("s_hsync_low_len", cnt, 3);
    chk("s_hsync_low_at", first, 10);

    first = -1;
    for (int k = 0; k < 16; k++)
      if (rec1[k].hb && first < 0) first = k;
    chk("s_hblnk_rise", first, 8);

    chk("s_line_h", int'(rec1[16].h), 0);
    chk("s_line_v", int'(rec1[16].v), 1);
    chk("s_line_ls", int'(rec1[16].ls), 1);
    chk("s_line_fs", int'(rec1[16].fs), 0);

    first = -1;
    for (int k = 0; k < 128; k++)
      if (rec1[k].vb && first < 0) first = k;
    chk("s_vblnk_rise", first, 64);

    cnt = 0; first = -1;
    for (int k = 0; k < 128; k++) begin
      if (!rec1[k].vs) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk("s_vsync_low_len", cnt, 32);
    chk("s_vsync_low_at", first, 80);

    chk("s_end_h", int'(rec1[127].h), 15);
    chk("s_end_v", int'(rec1[127].v), 7);
    chk("s_wrap_h", int'(rec1[128].h), 0);
    chk("s_wrap_v", int'(rec1[128].v), 0);

    first = -1;
    for (int k = 1; k < NREC; k++)
      if (rec1[k].fs && first < 0) first = k;
    chk("s_frame_period", first, 128);

    // Async reset mid-frame at (12,5), between edges
    n = 0;
    while (!(vif1.hcount == 11'd12 && vif1.vcount == 11'd5) && n < 400) begin
      step();
      n++;
    end
    found = (n < 400);
    chk("s_mid_reach", int'(found), 1);
    chk("s_mid_hb_pre", int'(vif1.hblnk), 1);
    #1 rst1_n = 1'b0;
    #1;
    chk("s_arst_h", int'(vif1.hcount), 0);
    chk("s_arst_v", int'(vif1.vcount), 0);
    chk("s_arst_hs", int'(vif1.hsync), 1);
    chk("s_arst_vs", int'(vif1.vsync), 1);
    chk("s_arst_hb", int'(vif1.hblnk), 0);
    chk("s_arst_vb", int'(vif1.vblnk), 0);
    chk("s_arst_ls", int'(ls1), 0);
    chk("s_arst_fs", int'(fs1), 0);
    repeat (3) step();
    rst1_n = 1'b1;
    for (int k = 0; k < NREC; k++) begin
      step();
      rec2[k] = smp1();
    end
    cnt = 0;
    for (int k = 0; k < NREC; k++)
      if (rec2[k] !== rec1[k]) cnt++;
    chk("s_restart_same", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
